output_collector: RTL and testbench
===================================

Name: output_collector

Overview:
- Consumer/arbiter at the far end of the output interface of RAM_curr_mem.
- Answers output_request with output_permit, then accepts the 512-bit result beats (output_data qualified by output_valid) until output_finish.
- Buffers the beats in a first-word-fall-through FIFO and forwards them to the host write path over a valid/ready stream.
- Drives stall back to the SMEM pipeline when the buffer nears full.

Parameters:
- DATA_W, 512, width of one output beat.
- DEPTH, 16, FIFO entries; power of two, at least 8.
- SKID, 4, free entries reserved to absorb beats still in flight after stall asserts.
- CNT_W, 16, width of the per-batch beat counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- output_request  in  1  producer has results ready to send.
- output_permit  out  1  grant; producer may send beats while this is high.
- output_data  in  DATA_W  result beat.
- output_valid  in  1  output_data valid this cycle.
- output_finish  in  1  last beat of the batch; may coincide with the last valid beat.
- stall  out  1  backpressure to the pipeline.
- host_data  out  DATA_W  FIFO head.
- host_valid  out  1  FIFO not empty.
- host_ready  in  1  host accepts the head this cycle.
- batch_done  out  1  one-cycle pulse when a batch is fully drained.
- beat_total  out  CNT_W  beat count of the last completed batch.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset values: output_permit=0, stall=0, host_valid=0, host_data=0, batch_done=0, beat_total=0, overflow=0. FIFO pointers and count cleared, state=IDLE.
- Reset mid-batch discards buffered beats and drops permit on the same edge.
- State machine, four states:
  - IDLE: if output_request=1, go to GRANT. output_permit goes high on the next edge (1-cycle grant latency). Beat counter is cleared.
  - GRANT: output_permit=1. Each cycle with output_valid=1, push output_data and increment the beat counter (saturates at all-ones). On output_finish=1, go to DRAIN; output_permit=0 from the next cycle. A valid beat in the finish cycle is pushed and counted.
  - DRAIN: permit=0. Any output_valid is ignored and sets overflow (protocol error). When the FIFO is empty and no pop is pending, go to DONE.
  - DONE: batch_done=1 for exactly one cycle; beat_total takes the counter value; return to IDLE. A new request is not granted in this cycle.
- output_valid while in IDLE: ignored, and overflow is set.
- FIFO: first-word-fall-through.
  - host_valid = count!=0; host_data = entry at the read pointer.
  - Pop when host_valid & host_ready.
  - Push while full: beat is dropped and overflow is set. Overflow clears only on reset.
  - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds.
  - Simultaneous push and pop at any count: count is unchanged, data order is preserved.
  - Pointers wrap modulo DEPTH.
- stall is registered: stall = 1 on the next edge when the post-update count >= DEPTH-SKID, else 0. stall is independent of state.
- output_finish with no valid beats: zero-beat batch. Passes through DRAIN and DONE with beat_total=0.
- Throughput: one beat per cycle in and one beat per cycle out when unstalled.

Test Plan:
- Reset, then request: permit high exactly 1 cycle later. 3 beats (data 1,2,3) sent, finish on the 3rd beat, host_ready=1 → host sees 1,2,3 in order, batch_done pulses once, beat_total=3, overflow=0.
- host_ready=0, 16 consecutive beats (DEPTH 16, SKID 4) → stall rises on the edge after the 12th push. Producer honours stall at 14 beats, then host_ready=1 → 14 beats out in order, no overflow.
- host_ready=0, producer ignores stall and sends 17 beats → first 16 stored, 17th dropped, overflow=1 and sticky through the next batch.
- Request with finish in the grant cycle and no valid beats → batch_done pulse, beat_total=0, host_valid never asserted.
- Full FIFO with host_ready=1 and output_valid=1 in the same cycle → count stays 16, no overflow, ordering intact.
- Reset asserted mid-GRANT with 5 beats buffered → next cycle permit=0, host_valid=0, stall=0. A subsequent request is granted normally.

Source files
------------

// File: rtl/output_collector.sv
// output_collector: far-end consumer of the RAM_curr_mem result interface.
// Grants a producer batch, buffers its 512-bit beats in a first-word-fall-
// through FIFO, streams them to the host write path over valid/ready, and
// raises a registered stall before the FIFO can overrun.
module output_collector #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16,
    parameter int SKID   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              output_request,
    output logic              output_permit,
    input  logic [DATA_W-1:0] output_data,
    input  logic              output_valid,
    input  logic              output_finish,
    output logic              stall,
    output logic [DATA_W-1:0] host_data,
    output logic              host_valid,
    input  logic              host_ready,
    output logic              batch_done,
    output logic [CNT_W-1:0]  beat_total,
    output logic              overflow
);

    // Pointer width and occupancy width (one extra bit so "full" is distinct).
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - SKID);

    // Batch sequencing states.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              stall_q, stall_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  beat_total_q, beat_total_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic push_req;
    logic pop;
    logic fifo_full;
    logic push_ok;
    logic push_drop;
    logic stray_beat;

    // Beat counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Next-state logic for the batch FSM and the per-batch beat counter.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        beat_total_d = beat_total_q;
        case (state_q)
            S_IDLE: begin
                beat_cnt_d = '0;
                if (output_request) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // A valid beat coinciding with finish still belongs to the batch.
                if (output_valid) begin
                    beat_cnt_d = sat_inc(beat_cnt_q);
                end
                if (output_finish) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // An empty FIFO cannot have a pop in flight, so count alone decides.
                if (count_q == '0) begin
                    state_d      = S_DONE;
                    beat_total_d = beat_cnt_q;
                end
            end
            S_DONE: begin
                // Deliberately no grant here; a pending request is seen from IDLE.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO push/pop decisions, occupancy, stall threshold and error tracking.
    always_comb begin
        push_req   = (state_q == S_GRANT) && output_valid;
        pop        = (count_q != '0) && host_ready;
        fifo_full  = (count_q == DEPTH_C);
        // A pop in the same cycle frees the slot the push needs.
        push_ok    = push_req && (!fifo_full || pop);
        push_drop  = push_req && !push_ok;
        // Beats outside a grant are protocol violations and are discarded.
        stray_beat = output_valid && (state_q != S_GRANT);

        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};

        // Stall looks at the post-update occupancy so SKID slots remain free.
        stall_d    = (count_d >= STALL_TH);
        overflow_d = overflow_q || push_drop || stray_beat;
    end

    // Control state: FSM, pointers, occupancy, stall, sticky error and stats.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            stall_q      <= 1'b0;
            overflow_q   <= 1'b0;
            beat_cnt_q   <= '0;
            beat_total_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            stall_q      <= stall_d;
            overflow_q   <= overflow_d;
            beat_cnt_q   <= beat_cnt_d;
            beat_total_q <= beat_total_d;
        end
    end

    // Beat storage; contents are only meaningful below the occupancy count,
    // so the array itself is never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= output_data;
        end
    end

    assign output_permit = (state_q == S_GRANT);
    assign stall         = stall_q;
    assign host_valid    = (count_q != '0);
    // Masked while empty so stale storage never appears on the host bus.
    assign host_data     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign batch_done    = (state_q == S_DONE);
    assign beat_total    = beat_total_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_output_collector.sv
// Self-checking bench for output_collector: scenario tasks with a scoreboard
// queue that the host-side monitor drains in order.
`timescale 1ns/1ps
module tb_output_collector;

    localparam int DATA_W = 512;
    localparam int DEPTH  = 16;
    localparam int SKID   = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              output_request;
    logic              output_permit;
    logic [DATA_W-1:0] output_data;
    logic              output_valid;
    logic              output_finish;
    logic              stall;
    logic [DATA_W-1:0] host_data;
    logic              host_valid;
    logic              host_ready;
    logic              batch_done;
    logic [CNT_W-1:0]  beat_total;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_d;

    output_collector #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .SKID(SKID), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .output_request(output_request), .output_permit(output_permit),
        .output_data(output_data), .output_valid(output_valid),
        .output_finish(output_finish), .stall(stall),
        .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
        .batch_done(batch_done), .beat_total(beat_total), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] beat(input int v);
        logic [31:0] w;
        w = v;
        return {16{w ^ 32'hA5000000}};
    endfunction

    // Host-side monitor: every accepted head must be the oldest expected beat.
    always @(negedge clk) begin
        if (reset === 1'b0 && host_valid === 1'b1 && host_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL host_order: got %h, required no beat", host_data);
            end else begin
                exp_d = exp_q.pop_front();
                if (host_data !== exp_d) begin
                    errors++;
                    $display("FAIL host_order: got %h, required %h", host_data, exp_d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        output_request = 1'b0;
        output_valid   = 1'b0;
        output_finish  = 1'b0;
        output_data    = '0;
    endtask

    // Observe (no comparisons) until the batch finishes, bounded in cycles.
    task automatic wait_batch(output int pulses, output logic [CNT_W-1:0] tot, output bit saw_valid);
        pulses    = 0;
        tot       = '0;
        saw_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (host_valid === 1'b1) saw_valid = 1'b1;
            if (batch_done === 1'b1) begin
                pulses++;
                tot = beat_total;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        host_ready = 1'b0;
        exp_q.delete();
        step();
        step();
        checks++; if (output_permit !== 1'b0) begin errors++; $display("FAIL reset_permit: got %b, required 0", output_permit); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, required 0", stall); end
        checks++; if (host_valid !== 1'b0) begin errors++; $display("FAIL reset_host_valid: got %b, required 0", host_valid); end
        checks++; if (host_data !== '0) begin errors++; $display("FAIL reset_host_data: got %h, required 0", host_data); end
        checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL reset_batch_done: got %b, required 0", batch_done); end
        checks++; if (beat_total !== '0) begin errors++; $display("FAIL reset_beat_total: got %0d, required 0", beat_total); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int pulses;
        logic [CNT_W-1:0] tot;
        bit sv;
        host_ready = 1'b1;
        output_request = 1'b1;
        #1;
        checks++; if (output_permit !== 1'b0) begin errors++; $display("FAIL basic_permit_latency: got %b, required 0", output_permit); end
        step();
        checks++; if (output_permit !== 1'b1) begin errors++; $display("FAIL basic_permit_grant: got %b, required 1", output_permit); end
        output_request = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            output_valid  = 1'b1;
            output_data   = DATA_W'(i);
            output_finish = (i == 3);
            exp_q.push_back(DATA_W'(i));
            step();
        end
        idle_inputs();
        checks++; if (output_permit !== 1'b0) begin errors++; $display("FAIL basic_permit_drop: got %b, required 0", output_permit); end
        wait_batch(pulses, tot, sv);
        checks++; if (pulses != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d, required 1", pulses); end
        checks++; if (tot !== 16'd3) begin errors++; $display("FAIL basic_beat_total: got %0d, required 3", tot); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b, required 0", overflow); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drained: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        int pulses;
        logic [CNT_W-1:0] tot;
        bit sv;
        logic exp_st;
        host_ready = 1'b0;
        output_request = 1'b1;
        step();
        output_request = 1'b0;
        for (int i = 0; i < 14; i++) begin
            output_valid  = 1'b1;
            output_data   = beat(100 + i);
            output_finish = (i == 13);
            exp_q.push_back(beat(100 + i));
            step();
            exp_st = ((i + 1) >= (DEPTH - SKID));
            checks++;
            if (stall !== exp_st) begin
                errors++;
                $display("FAIL stall_after_push_%0d: got %b, required %b", i + 1, stall, exp_st);
            end
        end
        idle_inputs();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stall_overflow: got %b, required 0", overflow); end
        host_ready = 1'b1;
        wait_batch(pulses, tot, sv);
        checks++; if (pulses != 1) begin errors++; $display("FAIL stall_done_pulses: got %0d, required 1", pulses); end
        checks++; if (tot !== 16'd14) begin errors++; $display("FAIL stall_beat_total: got %0d, required 14", tot); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drained: got %0d left, required 0", exp_q.size()); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_release: got %b, required 0", stall); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stall_overflow_end: got %b, required 0", overflow); end
    endtask

    task automatic test_overflow();
        int pulses;
        logic [CNT_W-1:0] tot;
        bit sv;
        host_ready = 1'b0;
        output_request = 1'b1;
        step();
        output_request = 1'b0;
        for (int i = 0; i < 17; i++) begin
            output_valid  = 1'b1;
            output_data   = beat(200 + i);
            output_finish = (i == 16);
            if (i < 16) exp_q.push_back(beat(200 + i));
            step();
            if (i == 15) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before_drop: got %b, required 0", overflow); end
            end
            if (i == 16) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_on_drop: got %b, required 1", overflow); end
            end
        end
        idle_inputs();
        host_ready = 1'b1;
        wait_batch(pulses, tot, sv);
        checks++; if (pulses != 1) begin errors++; $display("FAIL ovf_done_pulses: got %0d, required 1", pulses); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_drained: got %0d left, required 0", exp_q.size()); end
        // Next batch: overflow must stay set.
        output_request = 1'b1;
        step();
        output_request = 1'b0;
        for (int i = 0; i < 2; i++) begin
            output_valid  = 1'b1;
            output_data   = beat(300 + i);
            output_finish = (i == 1);
            exp_q.push_back(beat(300 + i));
            step();
        end
        idle_inputs();
        wait_batch(pulses, tot, sv);
        checks++; if (tot !== 16'd2) begin errors++; $display("FAIL ovf_next_total: got %0d, required 2", tot); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    endtask

    task automatic test_zero_beat();
        int pulses;
        logic [CNT_W-1:0] tot;
        bit sv;
        host_ready = 1'b1;
        output_request = 1'b1;
        step();
        output_request = 1'b0;
        output_finish  = 1'b1;
        step();
        idle_inputs();
        wait_batch(pulses, tot, sv);
        checks++; if (pulses != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d, required 1", pulses); end
        checks++; if (tot !== 16'd0) begin errors++; $display("FAIL zero_beat_total: got %0d, required 0", tot); end
        checks++; if (sv !== 1'b0) begin errors++; $display("FAIL zero_host_valid: got %b, required 0", sv); end
    endtask

    task automatic test_full_simul();
        int pulses;
        logic [CNT_W-1:0] tot;
        bit sv;
        host_ready = 1'b0;
        output_request = 1'b1;
        step();
        output_request = 1'b0;
        for (int i = 0; i < 16; i++) begin
            output_valid = 1'b1;
            output_data  = beat(400 + i);
            exp_q.push_back(beat(400 + i));
            step();
        end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b, required 1", stall); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_pre: got %b, required 0", overflow); end
        // Push and pop together while full.
        host_ready    = 1'b1;
        output_valid  = 1'b1;
        output_data   = beat(416);
        output_finish = 1'b1;
        exp_q.push_back(beat(416));
        step();
        idle_inputs();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_simul_overflow: got %b, required 0", overflow); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_simul_count: stall got %b, required 1", stall); end
        wait_batch(pulses, tot, sv);
        checks++; if (tot !== 16'd17) begin errors++; $display("FAIL full_beat_total: got %0d, required 17", tot); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_drained: got %0d left, required 0", exp_q.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_end: got %b, required 0", overflow); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic [CNT_W-1:0] tot;
        bit sv;
        host_ready = 1'b0;
        output_request = 1'b1;
        step();
        output_request = 1'b0;
        for (int i = 0; i < 5; i++) begin
            output_valid = 1'b1;
            output_data  = beat(500 + i);
            step();
        end
        idle_inputs();
        checks++; if (host_valid !== 1'b1) begin errors++; $display("FAIL rmid_buffered: got %b, required 1", host_valid); end
        reset = 1'b1;
        step();
        checks++; if (output_permit !== 1'b0) begin errors++; $display("FAIL rmid_permit: got %b, required 0", output_permit); end
        checks++; if (host_valid !== 1'b0) begin errors++; $display("FAIL rmid_host_valid: got %b, required 0", host_valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %b, required 0", stall); end
        reset = 1'b0;
        exp_q.delete();
        step();
        host_ready = 1'b1;
        output_request = 1'b1;
        #1;
        checks++; if (output_permit !== 1'b0) begin errors++; $display("FAIL rmid_regrant_latency: got %b, required 0", output_permit); end
        step();
        checks++; if (output_permit !== 1'b1) begin errors++; $display("FAIL rmid_regrant: got %b, required 1", output_permit); end
        output_request = 1'b0;
        for (int i = 0; i < 2; i++) begin
            output_valid  = 1'b1;
            output_data   = beat(600 + i);
            output_finish = (i == 1);
            exp_q.push_back(beat(600 + i));
            step();
        end
        idle_inputs();
        wait_batch(pulses, tot, sv);
        checks++; if (pulses != 1) begin errors++; $display("FAIL rmid_done_pulses: got %0d, required 1", pulses); end
        checks++; if (tot !== 16'd2) begin errors++; $display("FAIL rmid_beat_total: got %0d, required 2", tot); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_drained: got %0d left, required 0", exp_q.size()); end
    endtask

    initial begin
        reset      = 1'b1;
        host_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_reset();
        test_zero_beat();
        test_full_simul();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
